// File: rtl/bool_scan_pkg.sv
// rtl/bool_scan_pkg.sv - shared constants and state encoding for the truth-table scanner
package bool_scan_pkg;

   localparam int N_VEC                 = 16;
   localparam int IDX_W                 = 4;
   localparam int SETTLE_CYCLES_DEFAULT = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } scan_state_e;

endpackage

// File: rtl/scan_counter.sv
// rtl/scan_counter.sv - 4-bit vector index register with clear, saturating increment and last flag
module scan_counter
   import bool_scan_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             last_o
);

   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] idx_d;
   logic             last;

   assign last = (idx_q == IDX_W'(N_VEC - 1));

   // Next index: clear wins; increment stops at the last vector so a scan never wraps.
   always_comb begin
      idx_d = idx_q;
      if (clr_i) begin
         idx_d = '0;
      end else if (inc_i && !last) begin
         idx_d = idx_q + IDX_W'(1);
      end
   end

   // Index register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

   assign idx_o  = idx_q;
   assign last_o = last;

endmodule

// File: rtl/truth_table_scan.sv
// rtl/truth_table_scan.sv - walks all 16 input vectors of a 4-input function and captures its truth table
module truth_table_scan
   import bool_scan_pkg::*;
#(
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [N_VEC-1:0] expected,
   output logic             vec_a,
   output logic             vec_b,
   output logic             vec_c,
   output logic             vec_d,
   input  logic             f_in,
   output logic             busy,
   output logic             done,
   output logic [N_VEC-1:0] table_out,
   output logic             pass
);

   // Settle count runs 0..SETTLE_CYCLES-1 while a vector is held.
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   scan_state_e      state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [N_VEC-1:0] table_q, table_d;
   logic [N_VEC-1:0] exp_q, exp_d;
   logic             pass_q, pass_d;
   logic             done_q, done_d;
   logic             idx_clr;
   logic             idx_inc;
   logic [IDX_W-1:0] idx;
   logic             idx_last;

   scan_counter u_scan_counter (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (idx_clr),
      .inc_i  (idx_inc),
      .idx_o  (idx),
      .last_o (idx_last)
   );

   // Scan sequencing, table capture and result evaluation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      table_d = table_q;
      exp_d   = exp_q;
      pass_d  = pass_q;
      done_d  = 1'b0;
      idx_clr = 1'b0;
      idx_inc = 1'b0;
      case (state_q)
         IDLE: begin
            // abort beats a simultaneous start
            if (start && !abort) begin
               state_d = DRIVE;
               exp_d   = expected;
               table_d = '0;
               pass_d  = 1'b0;
               cnt_d   = '0;
               idx_clr = 1'b1;
            end
         end
         DRIVE: begin
            if (abort) begin
               state_d = IDLE;
               table_d = '0;
               pass_d  = 1'b0;
               cnt_d   = '0;
               idx_clr = 1'b1;
            end else if (cnt_q == SETTLE_LAST) begin
               state_d = SAMPLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         SAMPLE: begin
            if (abort) begin
               state_d = IDLE;
               table_d = '0;
               pass_d  = 1'b0;
               cnt_d   = '0;
               idx_clr = 1'b1;
            end else begin
               // f_in depends only on the registered vec_* outputs, so it is stable here
               table_d[idx] = f_in;
               if (idx_last) begin
                  state_d = DONE;
               end else begin
                  state_d = DRIVE;
                  idx_inc = 1'b1;
               end
            end
         end
         DONE: begin
            // done is registered so its pulse lines up with the final pass value
            state_d = IDLE;
            done_d  = 1'b1;
            pass_d  = (table_q == exp_q);
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, settle counter and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         table_q <= '0;
         exp_q   <= '0;
         pass_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         table_q <= table_d;
         exp_q   <= exp_d;
         pass_q  <= pass_d;
         done_q  <= done_d;
      end
   end

   assign {vec_a, vec_b, vec_c, vec_d} = idx;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign table_out = table_q;
   assign pass      = pass_q;

endmodule

// File: doc/truth_table_scan.md
TRUTH_TABLE_SCAN -- requirements
Module: truth_table_scan

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, giving the number of cycles each input vector is held before its response is sampled; legal range is 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a scan; sampled only in IDLE.
REQ-005 The block SHALL have port abort, input, 1 bit: cancel a scan in progress.
REQ-006 The block SHALL have port expected, input, 16 bits: golden truth table, bit i = required response to vector i.
REQ-007 The block SHALL have ports vec_a, vec_b, vec_c, vec_d, output, 1 bit each: registered drive to the 4-input boolean stage, with {vec_a,vec_b,vec_c,vec_d} = index[3:0].
REQ-008 The block SHALL have port f_in, input, 1 bit: the boolean stage's combinational response to the vec_* outputs.
REQ-009 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 The block SHALL have port done, output, 1 bit: single-cycle pulse when a scan completes.
REQ-011 The block SHALL have port table_out, output, 16 bits: the captured truth table.
REQ-012 The block SHALL have port pass, output, 1 bit: high when table_out equals the latched expected value.

Function
REQ-013 The FSM SHALL have states IDLE, DRIVE, SAMPLE and DONE.
REQ-014 In IDLE with start=1, the block SHALL latch expected, set index=0, clear table_out and pass, drive vec_*=0, and enter DRIVE on the next edge.
REQ-015 In DRIVE, vec_* SHALL hold index, and a settle counter SHALL count SETTLE_CYCLES cycles before the FSM moves to SAMPLE.
REQ-016 In SAMPLE, the block SHALL write f_in into table_out[index] on that edge.
REQ-017 From SAMPLE, if index==15 the FSM SHALL go to DONE; otherwise index SHALL increment, vec_* SHALL update, and the FSM SHALL return to DRIVE.
REQ-018 index SHALL be 4 bits wide and SHALL never wrap within a scan.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle, pass SHALL be set to (table_out == latched expected), and the FSM SHALL go to IDLE.
REQ-020 table_out and pass SHALL hold their values in IDLE until the next accepted start.
REQ-021 Timing: if start is sampled at edge k, done SHALL be high in the cycle after edge k+16*(SETTLE_CYCLES+1)+1, i.e. cycle 50 for the default.
REQ-022 busy SHALL be high from the cycle after start is accepted through the DONE cycle inclusive.
REQ-023 start asserted while busy SHALL be ignored and SHALL NOT restart or extend the scan.
REQ-024 abort=1 in DRIVE or SAMPLE SHALL return the FSM to IDLE on the next edge, drive vec_*=0, clear table_out and pass, and suppress done.
REQ-025 If start and abort are both high in IDLE, abort SHALL win and the scan SHALL NOT begin.
REQ-026 If abort coincides with the final SAMPLE (index==15), the block SHALL follow the abort path.
REQ-027 f_in SHALL be sampled directly without a synchronizer, because it depends only on registered vec_*.

Reset
REQ-028 While rst_n=0, the block SHALL force: state=IDLE, index=0, settle counter=0, vec_*=0, busy=0, done=0, table_out=16'h0000, pass=0, latched expected=0.
REQ-029 Reset asserted mid-scan SHALL take effect immediately, with no done pulse.
REQ-030 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Structure
REQ-031 Package bool_scan_pkg SHALL hold: the state encoding, N_VEC=16, IDX_W=4, and SETTLE_CYCLES_DEFAULT=2.
REQ-032 One sub-module, scan_counter, SHALL provide the 4-bit index register with clear, increment and last (index==15) flag.
REQ-033 The settle counter and FSM SHALL remain in the top module.

Verification
REQ-034 Connect f_in = (a&b&c)|(~a&~b)|d, expected=16'hEAAF, start pulse at cycle 0 -> done at cycle 50, table_out=16'hEAAF, pass=1.
REQ-035 Same connection with expected=16'hEAAE -> table_out=16'hEAAF, pass=0.
REQ-036 f_in tied 0, SETTLE_CYCLES=1 -> done at cycle 34, table_out=16'h0000.
REQ-037 abort at cycle 20 -> busy=0 and vec_*=0 by cycle 21, done never asserts, table_out=16'h0000.
REQ-038 start re-pulsed at cycles 5 and 30 during a scan -> single done at cycle 50, result unchanged.
REQ-039 rst_n low at cycle 25 for 3 cycles -> all outputs zero immediately; a fresh start after release completes normally.
